// File: rtl/l1_request_arbiter_pkg.sv
// Shared constants and types for the L1 request arbiter: requestor IDs and the
// request payload that is registered towards memory.
package l1_request_arbiter_pkg;

    localparam int L1_CONNECTIONS     = 4;
    localparam int L1_DCACHE_ID       = 0;
    localparam int L1_DMMU_ID         = 1;
    localparam int L1_ICACHE_ID       = 2;
    localparam int L1_IMMU_ID         = 3;
    localparam int L1_MAX_OUTSTANDING = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] data;
    } l1_arb_request_t;

    // Index width that stays at least one bit for single-entry configurations.
    function automatic int l1_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l1_request_arbiter_rsp_id_fifo.sv
// l1_rsp_id_fifo: in-order queue of requestor IDs for reads still awaiting
// their memory response; the head entry routes the next mem_rvalid.
module l1_rsp_id_fifo
    import l1_request_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head_id,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = l1_id_width(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Slot contents need no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            slots[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/l1_request_arbiter.sv
// Round-robin arbiter funnelling L1 requestors onto one registered memory port,
// routing in-order read data back. Define L1_ARB_DCACHE_PRIORITY_EN to let dcache always win.
module l1_request_arbiter
    import l1_request_arbiter_pkg::*;
#(
    parameter int L1_CONNECTIONS  = l1_request_arbiter_pkg::L1_CONNECTIONS,
    parameter int MAX_OUTSTANDING = l1_request_arbiter_pkg::L1_MAX_OUTSTANDING
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [L1_CONNECTIONS-1:0]      req_valid,
    input  logic [L1_CONNECTIONS-1:0][31:0] req_addr,
    input  logic [L1_CONNECTIONS-1:0]      req_rnw,
    input  logic [L1_CONNECTIONS-1:0][3:0] req_be,
    input  logic [L1_CONNECTIONS-1:0][31:0] req_data,
    output logic [L1_CONNECTIONS-1:0]      req_ack,
    output logic [L1_CONNECTIONS-1:0]      rsp_valid,
    output logic [31:0]                    rsp_data,
    output logic                           mem_req,
    output logic [31:0]                    mem_addr,
    output logic                           mem_rnw,
    output logic [3:0]                     mem_be,
    output logic [31:0]                    mem_data,
    input  logic                           mem_ack,
    input  logic                           mem_rvalid,
    input  logic [31:0]                    mem_rdata
);

    localparam int IDX_W = l1_id_width(L1_CONNECTIONS);

    l1_arb_request_t  held_req;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] head_id;
    logic             winner_found;
    logic             fifo_full;
    logic             fifo_empty;
    logic             arb_open;
    logic             accept;
    logic             rsp_pop;

    // A full ID queue blocks acceptance even if a response drains it this cycle.
    assign arb_open = rst_n && (!mem_req || mem_ack) && !fifo_full;
    assign accept   = arb_open && winner_found;
    assign rsp_pop  = rst_n && mem_rvalid && !fifo_empty;

    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        rr_idx       = '0;
`ifdef L1_ARB_DCACHE_PRIORITY_EN
        if (req_valid[L1_DCACHE_ID]) begin
            winner_found = 1'b1;
            winner       = IDX_W'(L1_DCACHE_ID);
        end
`endif
        for (int i = 0; i < L1_CONNECTIONS; i++) begin
            rr_idx = IDX_W'((int'(last_grant) + 1 + i) % L1_CONNECTIONS);
`ifdef L1_ARB_DCACHE_PRIORITY_EN
            if (!winner_found && rr_idx != IDX_W'(L1_DCACHE_ID) && req_valid[rr_idx]) begin
`else
            if (!winner_found && req_valid[rr_idx]) begin
`endif
                winner_found = 1'b1;
                winner       = rr_idx;
            end
        end
    end

    always_comb begin
        req_ack = '0;
        if (accept)
            req_ack[winner] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_pop)
            rsp_valid[head_id] = 1'b1;
    end

    assign rsp_data = mem_rdata;

    // A new acceptance replaces the held request even in the cycle mem_ack retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            held_req   <= '0;
            last_grant <= IDX_W'(L1_CONNECTIONS - 1);
        end else if (accept) begin
            mem_req    <= 1'b1;
            held_req   <= '{addr: req_addr[winner], rnw: req_rnw[winner],
                            be: req_be[winner], data: req_data[winner]};
            last_grant <= winner;
        end else if (mem_ack) begin
            mem_req    <= 1'b0;
        end
    end

    assign mem_addr = held_req.addr;
    assign mem_rnw  = held_req.rnw;
    assign mem_be   = held_req.be;
    assign mem_data = held_req.data;

    l1_rsp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_rsp_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept && req_rnw[winner]),
        .push_id (winner),
        .pop     (rsp_pop),
        .head_id (head_id),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

`ifndef SYNTHESIS
    rvalid_without_outstanding_read: assert property (
        @(posedge clk) disable iff (!rst_n) !(mem_rvalid && fifo_empty));
`endif

endmodule

// File: tb/tb_l1_request_arbiter.sv
// Self-checking bench for l1_request_arbiter: vector table plus hand sequences
// for stalls, queue-full blocking, response routing and mid-transaction reset.
module tb_l1_request_arbiter;
    import l1_request_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0][31:0]  req_addr;
    logic [N-1:0]        req_rnw;
    logic [N-1:0][3:0]   req_be;
    logic [N-1:0][31:0]  req_data;
    logic [N-1:0]        req_ack;
    logic [N-1:0]        rsp_valid;
    logic [31:0]         rsp_data;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_rnw;
    logic [3:0]          mem_be;
    logic [31:0]         mem_data;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [31:0]         mem_rdata;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] rnw;
        logic         ack;
        logic         rvalid;
        logic [31:0]  rdata;
        logic [N-1:0] exp_ack;
        logic         exp_mem_req;
    } vec_t;

    vec_t            vecs[$];
    l1_arb_request_t sent_q[$];
    l1_arb_request_t cur_exp;
    int              rsp_q[$];
    bit              sent_pending;
    int              tests_run    = 0;
    int              tests_failed = 0;
    logic [N-1:0]    phase_a [5];
    logic [N-1:0]    phase_d [4];

    always #5 clk = ~clk;

    l1_request_arbiter #(
        .L1_CONNECTIONS  (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_rnw    (req_rnw),
        .req_be     (req_be),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rnw    (mem_rnw),
        .mem_be     (mem_be),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rnw,
                                 input logic ack, input logic rvalid, input logic [31:0] rdata);
        req_valid  = valid;
        req_rnw    = rnw;
        mem_ack    = ack;
        mem_rvalid = rvalid;
        mem_rdata  = rdata;
    endtask

    task automatic addVec(input logic [N-1:0] valid, input logic [N-1:0] rnw, input logic ack,
                          input logic rvalid, input logic [31:0] rdata,
                          input logic [N-1:0] exp_ack, input logic exp_mem_req);
        vec_t v;
        v.valid       = valid;
        v.rnw         = rnw;
        v.ack         = ack;
        v.rvalid      = rvalid;
        v.rdata       = rdata;
        v.exp_ack     = exp_ack;
        v.exp_mem_req = exp_mem_req;
        vecs.push_back(v);
    endtask

    // Samples at the falling edge, updates the scoreboard, then steps past the next rising edge.
    task automatic checkCycle(input string tag, input logic [N-1:0] exp_ack,
                              input logic exp_mem_req, input logic rvalid_expected);
        logic [N-1:0] exp_rsp;
        int           id;
        @(negedge clk);
        checkOutput({tag, " req_ack"}, 64'(req_ack), 64'(exp_ack));
        checkOutput({tag, " mem_req"}, 64'(mem_req), 64'(exp_mem_req));
        if (sent_pending) begin
            cur_exp      = sent_q.pop_front();
            sent_pending = 1'b0;
        end
        if (exp_mem_req) begin
            checkOutput({tag, " mem_addr"}, 64'(mem_addr), 64'(cur_exp.addr));
            checkOutput({tag, " mem_rnw"}, 64'(mem_rnw), 64'(cur_exp.rnw));
            checkOutput({tag, " mem_be"}, 64'(mem_be), 64'(cur_exp.be));
            checkOutput({tag, " mem_data"}, 64'(mem_data), 64'(cur_exp.data));
        end
        exp_rsp = '0;
        if (rvalid_expected) begin
            if (rsp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL %s scoreboard: response expected, none outstanding", tag);
            end else begin
                id          = rsp_q.pop_front();
                exp_rsp[id] = 1'b1;
                checkOutput({tag, " rsp_data"}, 64'(rsp_data), 64'(mem_rdata));
            end
        end
        checkOutput({tag, " rsp_valid"}, 64'(rsp_valid), 64'(exp_rsp));
        for (int i = 0; i < N; i++) begin
            if (exp_ack[i]) begin
                sent_q.push_back('{addr: req_addr[i], rnw: req_rnw[i], be: req_be[i], data: req_data[i]});
                sent_pending = 1'b1;
                if (req_rnw[i])
                    rsp_q.push_back(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus('0, '0, 1'b0, 1'b0, 32'h0);
        sent_q.delete();
        rsp_q.delete();
        sent_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[i] = 32'h1000_0000 | (32'(i) << 8);
            req_data[i] = 32'hD000_0000 | 32'(i);
            req_be[i]   = 4'(4'hF - i);
        end
`ifdef L1_ARB_DCACHE_PRIORITY_EN
        phase_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        phase_d = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        phase_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        phase_d = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif

        // Reset state with every input trying to provoke activity.
        rst_n = 1'b0;
        applyStimulus('1, '1, 1'b1, 1'b1, 32'h5555_5555);
        @(negedge clk);
        checkOutput("reset mem_req", 64'(mem_req), 64'(0));
        checkOutput("reset req_ack", 64'(req_ack), 64'(0));
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("reset mem_data", 64'(mem_data), 64'(0));
        doReset();

        // Round robin from reset, idle drop, stalled hold, routing, back-to-back.
        for (int k = 0; k < 5; k++)
            addVec(4'hF, 4'h0, 1'b1, 1'b0, 32'h0, phase_a[k], k > 0);
        addVec(4'h0, 4'h0, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b1);
        addVec(4'h0, 4'h0, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b0);
        addVec(4'h8, 4'h8, 1'b0, 1'b0, 32'h0,         4'b1000, 1'b0);
        addVec(4'h1, 4'h1, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b1);
        addVec(4'h1, 4'h1, 1'b1, 1'b0, 32'h0,         4'b0001, 1'b1);
        addVec(4'h0, 4'h0, 1'b1, 1'b1, 32'h0000_000A, 4'b0000, 1'b1);
        addVec(4'h0, 4'h0, 1'b0, 1'b1, 32'h0000_000B, 4'b0000, 1'b0);
        addVec(4'h6, 4'h0, 1'b0, 1'b0, 32'h0,         4'b0010, 1'b0);
        addVec(4'h6, 4'h0, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b1);
        addVec(4'h6, 4'h0, 1'b1, 1'b0, 32'h0,         4'b0100, 1'b1);
        addVec(4'h0, 4'h0, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b1);
        addVec(4'h0, 4'h0, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0);
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].valid, vecs[k].rnw, vecs[k].ack, vecs[k].rvalid, vecs[k].rdata);
            checkCycle($sformatf("vec%0d", k), vecs[k].exp_ack, vecs[k].exp_mem_req, vecs[k].rvalid);
        end

        // Requestor 2 read stalled by mem_ack low for three cycles.
        doReset();
        req_addr[2] = 32'h4000_0010;
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0);
        checkCycle("stall accept", 4'b0100, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0);
            checkCycle($sformatf("stall hold%0d", k), 4'b0000, 1'b1, 1'b0);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
        checkCycle("stall ack", 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h1234_5678);
        checkCycle("stall rsp", 4'b0000, 1'b0, 1'b1);
        req_addr[2] = 32'h1000_0200;

        // Requestor 1 fills the ID queue; a pop frees a slot only one cycle later.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0);
            checkCycle($sformatf("fill%0d", k), 4'b0010, k > 0, 1'b0);
        end
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0);
        checkCycle("full blocked", 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0);
        checkCycle("full idle", 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b1, 32'hCAFE_0001);
        checkCycle("full pop", 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0);
        checkCycle("full reaccept", 4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0);
        checkCycle("full again", 4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 32'hCAFE_0010 + 32'(k));
            checkCycle($sformatf("drain%0d", k), 4'b0000, 1'b0, 1'b1);
        end

        // Reset with two reads outstanding discards them.
        doReset();
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0, 32'h0);
        checkCycle("mid first", 4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0);
        checkCycle("mid second", 4'b0010, 1'b1, 1'b0);
        rst_n = 1'b0;
        applyStimulus('1, '1, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("mid reset mem_req", 64'(mem_req), 64'(0));
        checkOutput("mid reset req_ack", 64'(req_ack), 64'(0));
        checkOutput("mid reset mem_addr", 64'(mem_addr), 64'(0));
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_0001;
        #1;
        checkOutput("mid reset rsp_valid", 64'(rsp_valid), 64'(0));
        doReset();
        applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0);
        checkCycle("post reset read", 4'b1000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_BEEF);
        checkCycle("post reset rsp", 4'b0000, 1'b1, 1'b1);

        // Requestors 0 and 2 continuously requesting.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0101, 4'b0000, 1'b1, 1'b0, 32'h0);
            checkCycle($sformatf("pair%0d", k), phase_d[k], k > 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/l1_request_arbiter.md
L1_REQUEST_ARBITER -- requirements
Module: l1_request_arbiter

Interface
REQ-001 SHALL have parameter L1_CONNECTIONS, default 4, number of requestors (dcache=0, dmmu=1, icache=2, immu=3).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, power of 2, maximum reads awaiting response.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  L1_CONNECTIONS  per-requestor request pending.
REQ-006 SHALL have ports req_addr  in  L1_CONNECTIONS x 32, req_rnw  in  L1_CONNECTIONS, req_be  in  L1_CONNECTIONS x 4, req_data  in  L1_CONNECTIONS x 32  per-requestor payload (rnw=1 read).
REQ-007 SHALL have port req_ack  out  L1_CONNECTIONS  one-hot, request accepted this cycle.
REQ-008 SHALL have ports rsp_valid  out  L1_CONNECTIONS, rsp_data  out  32  read response routing.
REQ-009 SHALL have ports mem_req  out  1, mem_addr  out  32, mem_rnw  out  1, mem_be  out  4, mem_data  out  32  registered memory request.
REQ-010 SHALL have ports mem_ack  in  1, mem_rvalid  in  1, mem_rdata  in  32  memory handshake and in-order read return.

Function
REQ-011 SHALL be "open" when mem_req=0 or (mem_req=1 and mem_ack=1), and not blocked.
REQ-012 SHALL be blocked when response-ID FIFO count equals MAX_OUTSTANDING, regardless of a same-cycle mem_rvalid pop.
REQ-013 When open and any req_valid set, SHALL select a winner round-robin starting at last_grant+1 modulo L1_CONNECTIONS, assert req_ack[winner] the same cycle, and register its payload.
REQ-014 SHALL assert mem_req the cycle after acceptance and hold mem_req and payload stable until mem_ack.
REQ-015 When open and no req_valid, SHALL deassert mem_req next cycle if mem_ack was received.
REQ-016 Back-to-back: mem_ack and new acceptance in the same cycle SHALL keep mem_req high with the new payload next cycle.
REQ-017 SHALL update last_grant only on acceptance.
REQ-018 SHALL push the winner index into the FIFO on acceptance of a read; writes SHALL NOT push.
REQ-019 SHALL drive rsp_valid[head]=mem_rvalid and rsp_data=mem_rdata combinationally, popping the FIFO on mem_rvalid (zero latency).
REQ-020 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-021 mem_rvalid with empty FIFO SHALL be ignored (no rsp_valid) and SHALL trigger a simulation assertion.
REQ-022 req_ack SHALL never be asserted for a requestor whose req_valid is low.

Reset
REQ-023 While rst_n=0: mem_req=0, req_ack=0, rsp_valid=0, FIFO empty, last_grant=L1_CONNECTIONS-1 (requestor 0 first), payload registers 0.
REQ-024 Reset asserted mid-transaction SHALL discard held request and all outstanding IDs; no responses routed afterward for them.

Configuration
REQ-025 With L1_ARB_DCACHE_PRIORITY_EN defined, requestor 0 SHALL win whenever its req_valid is set, others round-robin among themselves; without it all requestors are pure round-robin.

Structure
REQ-026 L1_CONNECTIONS, L1_*_ID constants and an l1_arb_request_t struct (addr, rnw, be, data) SHALL reside in the shared config/types package.
REQ-027 The response-ID queue SHALL be a sub-module l1_rsp_id_fifo (depth MAX_OUTSTANDING, width clog2(L1_CONNECTIONS)).

Verification
REQ-028 All four req_valid high from reset, mem_ack always 1 -> req_ack order 0,1,2,3,0 on consecutive cycles; mem_req continuously high.
REQ-029 Requestor 2 read addr 0x40000010, mem_ack held low 3 cycles -> mem_addr stable 0x40000010 4 cycles, single req_ack[2].
REQ-030 Five reads from requestor 1, no mem_rvalid -> fourth accepted, fifth not acked until one mem_rvalid pop plus one cycle.
REQ-031 Reads from 3 then 0, mem_rvalid with rdata 0xA then 0xB -> rsp_valid[3] with 0xA, then rsp_valid[0] with 0xB.
REQ-032 rst_n pulsed low with 2 reads outstanding -> mem_req=0, later mem_rvalid routes nowhere, assertion fires.
REQ-033 L1_ARB_DCACHE_PRIORITY_EN defined, req_valid 0 and 2 constantly high -> requestor 0 acked every cycle, 2 starved.
